// File: rtl/simon_phase_sequencer.sv
// Simon Says phase sequencer: one FSM that starts the generate, display,
//   input-wait and check phase blocks in turn and consumes their done pulses.
// Owns the round counter, the input-timeout watchdog and the win/lose status.
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   start_btn          start level; a rising edge starts a game from IDLE/WIN/LOSE
//   gen/disp/inp/chk_done  phase completion pulses; chk_pass qualifies chk_done
//   key_activity       button-press pulse that restarts the input watchdog
//   *_start, inp_abort one-cycle registered pulses to the phase blocks
//   round              0-based round index (sequence length = round+1)
//   busy, game_win, game_over, state_dbg  registered status/debug outputs
module simon_phase_sequencer #(
  parameter int MAX_ROUNDS     = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TW             = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       gen_done,
  input  logic       disp_done,
  input  logic       inp_done,
  input  logic       key_activity,
  input  logic       chk_done,
  input  logic       chk_pass,
  output logic       gen_start,
  output logic       disp_start,
  output logic       inp_start,
  output logic       inp_abort,
  output logic       chk_start,
  output logic [3:0] round,
  output logic       busy,
  output logic       game_win,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GEN  = 3'd1,
    S_DISP = 3'd2,
    S_INP  = 3'd3,
    S_CHK  = 3'd4,
    S_WIN  = 3'd5,
    S_LOSE = 3'd6
  } state_t;

  localparam logic [TW-1:0] LAST_CNT   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_ROUND = 4'(MAX_ROUNDS - 1);

  state_t          state_q, state_d;
  logic            start_q;
  logic [3:0]      round_q, round_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            timeout_d;
  logic            start_edge;

  logic gen_start_q, disp_start_q, inp_start_q, inp_abort_q, chk_start_q;
  logic busy_q, win_q, over_q;
  logic gen_start_d, disp_start_d, inp_start_d, chk_start_d;
  logic busy_d, win_d, over_d;

  assign start_edge = start_btn & ~start_q;

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b1;  // a button held through reset must not start a game
      round_q      <= '0;
      cnt_q        <= '0;
      gen_start_q  <= 1'b0;
      disp_start_q <= 1'b0;
      inp_start_q  <= 1'b0;
      inp_abort_q  <= 1'b0;
      chk_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      win_q        <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_btn;
      round_q      <= round_d;
      cnt_q        <= cnt_d;
      gen_start_q  <= gen_start_d;
      disp_start_q <= disp_start_d;
      inp_start_q  <= inp_start_d;
      inp_abort_q  <= timeout_d;
      chk_start_q  <= chk_start_d;
      busy_q       <= busy_d;
      win_q        <= win_d;
      over_q       <= over_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_edge) begin
          state_d = S_GEN;
          round_d = '0;
        end
      end
      S_GEN: if (gen_done) state_d = S_DISP;
      S_DISP: begin
        if (disp_done) begin
          state_d = S_INP;
          cnt_d   = '0;
        end
      end
      S_INP: begin
        // Completion wins over a same-cycle expiry; activity restarts the watchdog.
        if (inp_done) begin
          state_d = S_CHK;
        end else if (key_activity) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = S_LOSE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_CHK: begin
        if (chk_done) begin
          if (!chk_pass) begin
            state_d = S_LOSE;
          end else if (round_q == LAST_ROUND) begin
            state_d = S_WIN;  // checked before incrementing, so round never wraps
          end else begin
            state_d = S_DISP;  // memory is filled once per game: skip GEN
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the
  // upcoming state so every output lines up with the state it describes.
  always_comb begin
    gen_start_d  = (state_d != state_q) && (state_d == S_GEN);
    disp_start_d = (state_d != state_q) && (state_d == S_DISP);
    inp_start_d  = (state_d != state_q) && (state_d == S_INP);
    chk_start_d  = (state_d != state_q) && (state_d == S_CHK);
    busy_d       = (state_d == S_GEN) || (state_d == S_DISP) ||
                   (state_d == S_INP) || (state_d == S_CHK);
    win_d        = (state_d == S_WIN);
    over_d       = (state_d == S_LOSE);
  end

  assign gen_start  = gen_start_q;
  assign disp_start = disp_start_q;
  assign inp_start  = inp_start_q;
  assign inp_abort  = inp_abort_q;
  assign chk_start  = chk_start_q;
  assign round      = round_q;
  assign busy       = busy_q;
  assign game_win   = win_q;
  assign game_over  = over_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_simon_phase_sequencer.sv
// Bench for simon_phase_sequencer (MAX_ROUNDS=4, TIMEOUT_CYCLES=8).
// Each driven cycle pushes the expected post-edge outputs from a game-level
// model into a queue; a monitor pops and compares after every clock edge.
module tb_simon_phase_sequencer;

  localparam int MAXR = 4;
  localparam int TO   = 8;

  // Debug codes of the game phases as seen on state_dbg.
  localparam int P_IDLE = 0, P_GEN = 1, P_DISP = 2, P_INP = 3, P_CHK = 4,
                 P_WIN = 5, P_LOSE = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_btn, gen_done, disp_done, inp_done, key_activity, chk_done, chk_pass;
  logic gen_start, disp_start, inp_start, inp_abort, chk_start;
  logic [3:0] round;
  logic busy, game_win, game_over;
  logic [2:0] state_dbg;

  simon_phase_sequencer #(.MAX_ROUNDS(MAXR), .TIMEOUT_CYCLES(TO), .TW(4)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .gen_done(gen_done),
    .disp_done(disp_done), .inp_done(inp_done), .key_activity(key_activity),
    .chk_done(chk_done), .chk_pass(chk_pass), .gen_start(gen_start),
    .disp_start(disp_start), .inp_start(inp_start), .inp_abort(inp_abort),
    .chk_start(chk_start), .round(round), .busy(busy), .game_win(game_win),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic rst, sb, gd, dd, id, ka, cd, cp;
  } in_t;

  typedef struct packed {
    logic [7:0] flags;  // gen_start,disp_start,inp_start,inp_abort,chk_start,busy,win,over
    logic [3:0] rnd;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Game-level reference model.
  int m_phase = P_IDLE;
  int m_round = 0;
  int m_idle  = 0;   // idle INP cycles since last activity
  bit m_sb_prev = 1'b1;

  function automatic exp_t model_step(input in_t v);
    exp_t e;
    int   prev;
    bit   edge_seen, aborted;
    e = '0;
    if (v.rst) begin
      m_phase = P_IDLE; m_round = 0; m_idle = 0; m_sb_prev = 1'b1;
      return e;
    end
    edge_seen = v.sb && !m_sb_prev;
    m_sb_prev = v.sb;
    prev      = m_phase;
    aborted   = 1'b0;
    if (m_phase == P_IDLE || m_phase == P_WIN || m_phase == P_LOSE) begin
      if (edge_seen) begin m_phase = P_GEN; m_round = 0; end
    end else if (m_phase == P_GEN) begin
      if (v.gd) m_phase = P_DISP;
    end else if (m_phase == P_DISP) begin
      if (v.dd) begin m_phase = P_INP; m_idle = 0; end
    end else if (m_phase == P_INP) begin
      if (v.id) m_phase = P_CHK;
      else if (v.ka) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TO) begin m_phase = P_LOSE; aborted = 1'b1; end
      end
    end else if (m_phase == P_CHK && v.cd) begin
      if (!v.cp) m_phase = P_LOSE;
      else if (m_round + 1 == MAXR) m_phase = P_WIN;
      else begin m_round++; m_phase = P_DISP; end
    end
    e.flags[7] = (m_phase != prev) && (m_phase == P_GEN);
    e.flags[6] = (m_phase != prev) && (m_phase == P_DISP);
    e.flags[5] = (m_phase != prev) && (m_phase == P_INP);
    e.flags[4] = aborted;
    e.flags[3] = (m_phase != prev) && (m_phase == P_CHK);
    e.flags[2] = (m_phase >= P_GEN) && (m_phase <= P_CHK);
    e.flags[1] = (m_phase == P_WIN);
    e.flags[0] = (m_phase == P_LOSE);
    e.rnd      = 4'(m_round);
    e.st       = 3'(m_phase);
    return e;
  endfunction

  // Called at a falling edge: drive one cycle, queue its expectation, advance.
  task automatic tick(input in_t v);
    reset = v.rst; start_btn = v.sb; gen_done = v.gd; disp_done = v.dd;
    inp_done = v.id; key_activity = v.ka; chk_done = v.cd; chk_pass = v.cp;
    exp_q.push_back(model_step(v));
    @(negedge clk);
  endtask

  // Wait (bounded) for the model to reach a phase, then deliver its done pulse.
  task automatic finish(input int ph, input bit pass);
    in_t v;
    bit  done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      v = '0;
      if (m_phase == ph) begin
        if ($urandom_range(0, 1) == 1) tick(v);
        v = '0;
        case (ph)
          P_GEN:  v.gd = 1'b1;
          P_DISP: v.dd = 1'b1;
          P_INP:  v.id = 1'b1;
          default: begin v.cd = 1'b1; v.cp = pass; end
        endcase
        tick(v);
        done = 1'b1;
      end else begin
        tick(v);
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL phase_reach: model phase %0d, required %0d within 40 cycles", m_phase, ph);
    end
  endtask

  task automatic start_game();
    in_t v;
    v = '0; tick(v);
    v.sb = 1'b1; tick(v);
    v.sb = 1'b0; tick(v);
  endtask

  task automatic spurious_dones(input int n);
    in_t v;
    v = '0; v.gd = 1'b1; v.dd = 1'b1; v.id = 1'b1; v.cd = 1'b1; v.cp = 1'b1;
    repeat (n) tick(v);
  endtask

  // Monitor: every edge presents a full output set; compare against the queue.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {gen_start, disp_start, inp_start, inp_abort, chk_start,
               busy, game_win, game_over, round, state_dbg};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          if (n_fail <= 25)
            $display("FAIL outputs t=%0t: got st=%0d rnd=%0d flags=%b, required st=%0d rnd=%0d flags=%b",
                     $time, got.st, got.rnd, got.flags, e.st, e.rnd, e.flags);
        end
      end
    end
  end

  initial begin
    in_t v;
    bit  sb_lvl;
    reset = 1'b1; start_btn = 1'b0; gen_done = 1'b0; disp_done = 1'b0;
    inp_done = 1'b0; key_activity = 1'b0; chk_done = 1'b0; chk_pass = 1'b0;
    @(negedge clk);

    // Button held high through reset release: no game starts.
    v = '0; v.rst = 1'b1; v.sb = 1'b1; tick(v); tick(v);
    v.rst = 1'b0; repeat (3) tick(v);
    v.sb = 1'b0; tick(v);

    // Full game to WIN, dones ignored afterwards, then restart from WIN.
    start_game();
    finish(P_GEN, 1'b0);
    repeat (MAXR) begin
      finish(P_DISP, 1'b0); finish(P_INP, 1'b0); finish(P_CHK, 1'b1);
    end
    spurious_dones(3);
    start_game();

    // Lose on round 2, dones ignored in LOSE.
    finish(P_GEN, 1'b0);
    repeat (2) begin
      finish(P_DISP, 1'b0); finish(P_INP, 1'b0); finish(P_CHK, 1'b1);
    end
    finish(P_DISP, 1'b0); finish(P_INP, 1'b0); finish(P_CHK, 1'b0);
    spurious_dones(4);

    // Input timeout with no activity.
    start_game();
    finish(P_GEN, 1'b0); finish(P_DISP, 1'b0);
    v = '0; repeat (12) tick(v);

    // Activity every 5 cycles keeps the watchdog from expiring.
    start_game();
    finish(P_GEN, 1'b0); finish(P_DISP, 1'b0);
    for (int i = 0; i < 30; i++) begin
      v = '0; v.ka = (i % 5 == 4); tick(v);
    end
    finish(P_INP, 1'b0); finish(P_CHK, 1'b0);

    // inp_done on the expiry cycle: check wins, no abort.
    start_game();
    finish(P_GEN, 1'b0); finish(P_DISP, 1'b0);
    v = '0; repeat (TO - 1) tick(v);
    v.id = 1'b1; tick(v);
    finish(P_CHK, 1'b1);

    // Reset while in DISP.
    v = '0; tick(v);
    v.rst = 1'b1; tick(v);
    v = '0; tick(v);

    // Start presses while busy are ignored.
    start_game();
    v = '0; v.sb = 1'b1; tick(v);
    v.sb = 1'b0; tick(v);
    finish(P_GEN, 1'b0);
    v.sb = 1'b1; tick(v);
    v.sb = 1'b0; tick(v);

    // Randomized play with spurious pulses, button noise and occasional reset.
    sb_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      v = '0;
      if ($urandom_range(0, 19) == 0) sb_lvl = ~sb_lvl;
      v.sb  = sb_lvl;
      v.rst = ($urandom_range(0, 499) == 0);
      v.gd  = (m_phase == P_GEN)  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
      v.dd  = (m_phase == P_DISP) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
      v.id  = (m_phase == P_INP)  ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 24) == 0);
      v.ka  = ($urandom_range(0, 4) == 0);
      v.cd  = (m_phase == P_CHK)  ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 24) == 0);
      v.cp  = ($urandom_range(0, 7) != 0);
      tick(v);
    end

    // Drain the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
